// File: rtl/cpu_pkg.sv
// Shared definitions for the store-merge unit: FSM state encoding and the
// address-alignment rules that select between word, halfword and error paths.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_ERR   = 2'd3
  } smu_state_t;

  // Low address bits that must be zero for each access size
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
  localparam logic [1:0] HALF_ALIGN_MASK = 2'b01;

  function automatic smu_state_t store_next_state(input logic sh, input logic [1:0] lo);
    smu_state_t nxt;
    nxt = ST_ERR;
    if (!sh && ((lo & WORD_ALIGN_MASK) == 2'b00)) begin
      nxt = ST_WRITE;
    end else if (sh && ((lo & HALF_ALIGN_MASK) == 2'b00)) begin
      nxt = ST_READ;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/hw_merge.sv
// Places a 16-bit halfword into the low or high half of an existing word
// (little-endian: select=1 means the upper halfword).
module hw_merge (
  input  logic [31:0] i_old,
  input  logic [15:0] i_half,
  input  logic        i_sel,
  output logic [31:0] o_merged
);

  assign o_merged = i_sel ? {i_half, i_old[15:0]} : {i_old[31:16], i_half};

endmodule

// File: rtl/store_merge_unit.sv
// Store unit: word stores write directly, halfword stores read-modify-write
// the containing word, misaligned stores raise a one-cycle error pulse.
module store_merge_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              SH,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata
);

  smu_state_t        r_state;
  logic [ADDR_W-1:0] r_waddr;
  logic              r_hsel;
  logic              r_sh;
  logic [31:0]       r_wdata;
  logic [31:0]       w_merged;
  logic              w_unused_addr;

  // Requests are only looked at in IDLE; anything arriving while busy is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_waddr <= '0;
      r_hsel  <= 1'b0;
      r_sh    <= 1'b0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_waddr <= addr[ADDR_W+1:2];
            r_hsel  <= addr[1];
            r_sh    <= SH;
            r_wdata <= wdata;
            r_state <= store_next_state(SH, addr[1:0]);
          end
        end
        ST_READ: r_state <= ST_WRITE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Reset gates the strobes immediately so an aborted operation never writes
  assign busy   = !rst && (r_state != ST_IDLE);
  assign done   = !rst && (r_state == ST_WRITE);
  assign mem_we = !rst && (r_state == ST_WRITE);
  assign err    = !rst && (r_state == ST_ERR);

  // In IDLE the incoming address goes straight to memory; afterwards the captured one
  assign mem_addr = (r_state == ST_IDLE) ? addr[ADDR_W+1:2] : r_waddr;

  hw_merge u_hw_merge (
    .i_old    (mem_rdata),
    .i_half   (r_wdata[15:0]),
    .i_sel    (r_hsel),
    .o_merged (w_merged)
  );

  assign mem_wdata = r_sh ? w_merged : r_wdata;

  assign w_unused_addr = ^addr[31:ADDR_W+2];

endmodule

// File: doc/store_merge_unit.md
STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 SHALL provide parameter ADDR_W, default 10, word-address width of data memory.
REQ-002 SHALL provide port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port req  input  1  store request valid, sampled only in IDLE.
REQ-005 SHALL provide port SH  input  1  1 = store halfword, 0 = store word; driven by decoder SH signal.
REQ-006 SHALL provide port addr  input  32  byte address of store.
REQ-007 SHALL provide port wdata  input  32  register data to store; halfword uses wdata[15:0].
REQ-008 SHALL provide port busy  output  1  high in any non-IDLE state.
REQ-009 SHALL provide port done  output  1  one-cycle pulse in the cycle the memory write occurs.
REQ-010 SHALL provide port err  output  1  one-cycle pulse on misaligned request; no write.
REQ-011 SHALL provide port mem_addr  output  ADDR_W  word address = captured addr[ADDR_W+1:2].
REQ-012 SHALL provide port mem_rdata  input  32  synchronous-read memory data, valid one cycle after mem_addr presented.
REQ-013 SHALL provide port mem_we  output  1  memory write enable.
REQ-014 SHALL provide port mem_wdata  output  32  memory write data.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WRITE, ERR.
REQ-016 IDLE with req=1: SHALL capture addr, wdata, SH into registers; next state WRITE if SH=0 and addr[1:0]=00; READ if SH=1 and addr[0]=0; ERR otherwise.
REQ-017 IDLE with req=0: SHALL remain IDLE; req while busy SHALL be ignored (not queued).
REQ-018 READ: SHALL drive mem_addr from captured address, mem_we=0; next state WRITE unconditionally.
REQ-019 WRITE: SHALL assert mem_we=1 and done=1 for exactly one cycle; next state IDLE.
REQ-020 Word store in WRITE: mem_wdata SHALL equal captured wdata.
REQ-021 Halfword store in WRITE: captured addr[1]=0 -> mem_wdata = {mem_rdata[31:16], wdata[15:0]}; addr[1]=1 -> {wdata[15:0], mem_rdata[15:0]} (little-endian halfword placement).
REQ-022 ERR: SHALL assert err=1 one cycle, mem_we=0, done=0; next state IDLE.
REQ-023 Latency from accepting cycle N: word store mem_we/done at N+1; halfword at N+2; misaligned err at N+1.
REQ-024 busy SHALL be 0 in IDLE, 1 in READ, WRITE, ERR; new req SHALL be accepted in the cycle after done/err.
REQ-025 mem_we, done, err SHALL never be asserted in the same cycle as each other except done with mem_we.
REQ-026 mem_addr SHALL hold captured value from READ through WRITE; in IDLE SHALL present addr[ADDR_W+1:2] combinationally.
REQ-027 Address bits above ADDR_W+1 SHALL be ignored (wrap modulo memory size).

Reset
REQ-028 rst=1 at a clock edge SHALL force state IDLE and clear captured registers to 0, from any state.
REQ-029 While rst=1, mem_we, done, err, busy SHALL be 0 combinationally; reset mid-READ/WRITE SHALL abort with no memory write.
REQ-030 After reset deassertion, first req SHALL be accepted in the first cycle with rst=0.

Structure
REQ-031 State encoding and the alignment-check constants SHALL live in shared package cpu_pkg.
REQ-032 Halfword merge datapath SHALL be a sub-module hw_merge (inputs old word, halfword, select; output merged word), purely combinational.

Verification
REQ-033 Word store: req, SH=0, addr=0x0000_0010, wdata=0xDEADBEEF -> N+1: mem_we=1, mem_addr=4, mem_wdata=0xDEADBEEF, done=1.
REQ-034 Halfword low: memory word 4 = 0x11223344; SH=1, addr=0x10, wdata=0x0000ABCD -> N+2: mem_wdata=0x1122ABCD, done=1.
REQ-035 Halfword high: same memory; addr=0x12, wdata=0xFFFF5566 -> N+2: mem_wdata=0x55663344.
REQ-036 Misaligned: SH=1 addr=0x11 -> N+1 err=1, mem_we=0; SH=0 addr=0x12 -> same.
REQ-037 Reset mid-op: halfword req, rst=1 in READ cycle -> no mem_we ever, busy=0 next cycle; word req right after rst drops completes normally.
REQ-038 Back-to-back: req held high with two word stores -> second write exactly two cycles after first; req asserted during busy ignored.
